// File: rtl/mem_load_ctrl_if.sv
// Load-request and data-bus signal bundle for mem_load_ctrl.
// The master modport is the load sequencer; the slave modport is the MEM stage and data bus.
interface mem_load_ctrl_if;
   logic        mem_load_valid;
   logic        mem_load_byte;
   logic        mem_load_unsigned;
   logic [31:0] mem_addr;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        mem_stop_end;
   logic [31:0] mem_load_data;
   logic        mem_load_busy;
   logic        mem_load_err;

   modport master (
      input  mem_load_valid, mem_load_byte, mem_load_unsigned, mem_addr,
      input  bus_ack, bus_rdata,
      output bus_req, bus_addr, bus_be,
      output mem_stop_end, mem_load_data, mem_load_busy, mem_load_err
   );

   modport slave (
      output mem_load_valid, mem_load_byte, mem_load_unsigned, mem_addr,
      output bus_ack, bus_rdata,
      input  bus_req, bus_addr, bus_be,
      input  mem_stop_end, mem_load_data, mem_load_busy, mem_load_err
   );
endinterface

// File: rtl/mem_load_ctrl.sv
// MEM-stage load sequencer: req/ack bus read, byte/word extend, one-cycle mem_stop_end (valid->pulse 2 cycles + ack waits).
// Holds bus_req until bus_ack; optional REQ timeout abort under MEM_LOAD_TIMEOUT_EN.
module mem_load_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   mem_load_ctrl_if.master ld
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_load_ctrl: TIMEOUT must be 1..255");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        byte_q, byte_d;
   logic        uns_q, uns_d;
   logic [31:0] data_q, data_d;
   logic [31:0] lane;
   logic [7:0]  sel_byte;
   logic [31:0] result;

`ifdef MEM_LOAD_TIMEOUT_EN
   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        timeout_hit;

   assign timeout_hit = ((cnt_q + 8'd1) == TO_CNT);
`endif

   // Byte lane is picked from the captured address, not the live MEM-stage one.
   assign lane     = ld.bus_rdata >> {addr_q[1:0], 3'b000};
   assign sel_byte = lane[7:0];
   assign result   = !byte_q ? ld.bus_rdata
                   : uns_q   ? {24'h000000, sel_byte}
                   :           {{24{sel_byte[7]}}, sel_byte};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      byte_d  = byte_q;
      uns_d   = uns_q;
      data_d  = data_q;
`ifdef MEM_LOAD_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ld.mem_load_valid) begin
               addr_d  = ld.mem_addr;
               byte_d  = ld.mem_load_byte;
               uns_d   = ld.mem_load_unsigned;
               state_d = S_REQ;
`ifdef MEM_LOAD_TIMEOUT_EN
               cnt_d   = 8'd0;
               err_d   = 1'b0;
`endif
            end
         end
         S_REQ: begin
            if (ld.bus_ack) begin
               data_d  = result;
               state_d = S_DONE;
            end
`ifdef MEM_LOAD_TIMEOUT_EN
            else if (timeout_hit) begin
               data_d  = 32'h0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0;
         byte_q  <= 1'b0;
         uns_q   <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
         uns_q   <= uns_d;
         data_q  <= data_d;
      end
   end

`ifdef MEM_LOAD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign ld.mem_load_err = err_q;
`else
   assign ld.mem_load_err = 1'b0;
`endif

   assign ld.bus_req       = (state_q == S_REQ);
   assign ld.bus_addr      = {addr_q[31:2], 2'b00};
   assign ld.bus_be        = (state_q != S_REQ) ? 4'h0
                           : byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
   assign ld.mem_stop_end  = (state_q == S_DONE);
   assign ld.mem_load_busy = (state_q != S_IDLE);
   assign ld.mem_load_data = data_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Self-checking bench for mem_load_ctrl: directed test-plan loads plus randomized loads against a reference model.
module tb_mem_load_ctrl;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   mem_load_ctrl_if ld_if ();

   mem_load_ctrl #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .ld  (ld_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ld_if.mem_stop_end === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic byt,
                                             input logic uns, input logic [31:0] rd);
      int unsigned sh;
      int unsigned b;
      sh = a % 4;
      b  = (rd >> (8 * sh)) & 255;
      if (!byt) return rd;
      if (uns || b < 128) return b;
      return b + 32'hFFFF_FF00;
   endfunction

   function automatic logic [3:0] ref_be(input logic [31:0] a, input logic byt);
      if (!byt) return 4'd15;
      return 4'(1 << (a % 4));
   endfunction

   function automatic bit times_out(input int w);
`ifdef MEM_LOAD_TIMEOUT_EN
      return w >= TO;
`else
      return 1'b0;
`endif
   endfunction

   // Starts in IDLE at #1 after a rising edge; w = ack wait cycles after bus_req rises.
   task automatic do_load(input logic [31:0] a, input logic byt, input logic uns,
                          input logic [31:0] rd, input int w);
      logic [31:0] exp_d;
      bit          tout;
      int          n_req;
      int          p0;
      exp_d = ref_load(a, byt, uns, rd);
      tout  = times_out(w);
      n_req = tout ? TO : w;
      p0    = pulses;
      ld_if.mem_load_valid    = 1'b1;
      ld_if.mem_addr          = a;
      ld_if.mem_load_byte     = byt;
      ld_if.mem_load_unsigned = uns;
      @(posedge clk); #1;
      ld_if.mem_addr = $urandom;
      ld_if.mem_load_byte = 1'($urandom);
      ld_if.mem_load_unsigned = 1'($urandom);
      for (int i = 0; i <= n_req; i++) begin
         if (i == n_req && tout) break;
         ld_if.mem_load_valid = 1'($urandom);
         ld_if.bus_rdata = $urandom;
         check("req", 32'(ld_if.bus_req), 32'd1);
         check("bus_addr", ld_if.bus_addr, a & 32'hFFFF_FFFC);
         check("bus_be", 32'(ld_if.bus_be), 32'(ref_be(a, byt)));
         check("stop_in_req", 32'(ld_if.mem_stop_end), 32'd0);
         check("busy_req", 32'(ld_if.mem_load_busy), 32'd1);
         if (i == n_req) begin
            ld_if.bus_ack = 1'b1;
            ld_if.bus_rdata = rd;
         end
         @(posedge clk); #1;
         ld_if.bus_ack = 1'b0;
      end
      ld_if.bus_rdata = $urandom;
      ld_if.mem_load_valid = 1'($urandom);
      check("stop_done", 32'(ld_if.mem_stop_end), 32'd1);
      check("req_done", 32'(ld_if.bus_req), 32'd0);
      check("busy_done", 32'(ld_if.mem_load_busy), 32'd1);
      check("data", ld_if.mem_load_data, tout ? 32'h0 : exp_d);
      check("err", 32'(ld_if.mem_load_err), 32'(tout));
      @(posedge clk); #1;
      ld_if.mem_load_valid = 1'b0;
      check("stop_idle", 32'(ld_if.mem_stop_end), 32'd0);
      check("busy_idle", 32'(ld_if.mem_load_busy), 32'd0);
      check("data_hold", ld_if.mem_load_data, tout ? 32'h0 : exp_d);
      check("err_hold", 32'(ld_if.mem_load_err), 32'(tout));
      check("one_pulse", 32'(pulses - p0), 32'd1);
   endtask

   initial begin
      int p0;
      logic [31:0] ra;
      ld_if.mem_load_valid    = 1'b0;
      ld_if.mem_load_byte     = 1'b0;
      ld_if.mem_load_unsigned = 1'b0;
      ld_if.mem_addr          = 32'h0;
      ld_if.bus_ack           = 1'b0;
      ld_if.bus_rdata         = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", 32'(ld_if.bus_req), 32'd0);
      check("rst_addr", ld_if.bus_addr, 32'h0);
      check("rst_be", 32'(ld_if.bus_be), 32'h0);
      check("rst_stop", 32'(ld_if.mem_stop_end), 32'd0);
      check("rst_data", ld_if.mem_load_data, 32'h0);
      check("rst_busy", 32'(ld_if.mem_load_busy), 32'd0);
      check("rst_err", 32'(ld_if.mem_load_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Test-plan loads
      do_load(32'h0000_0100, 1'b0, 1'b0, 32'hDEAD_BEEF, 3);
      check("lw_const", ld_if.mem_load_data, 32'hDEAD_BEEF);
      do_load(32'h0000_0103, 1'b1, 1'b0, 32'h8011_2233, 0);
      check("lb_const", ld_if.mem_load_data, 32'hFFFF_FF80);
      do_load(32'h0000_0101, 1'b1, 1'b1, 32'h0000_F100, 1);
      check("lbu_const", ld_if.mem_load_data, 32'h0000_00F1);
      do_load(32'h0000_0101, 1'b1, 1'b0, 32'h0000_F100, 0);
      check("lb_f1_const", ld_if.mem_load_data, 32'hFFFF_FFF1);
      do_load(32'h0000_0206, 1'b0, 1'b0, 32'h1234_5678, 2);

      // Back-to-back with valid held high through DONE
      p0 = pulses;
      ld_if.mem_load_valid = 1'b1;
      ld_if.mem_addr = 32'h0000_0400;
      ld_if.mem_load_byte = 1'b0;
      @(posedge clk); #1;
      ld_if.bus_ack = 1'b1;
      ld_if.bus_rdata = 32'hA5A5_0001;
      ld_if.mem_addr = 32'h0000_0502;
      ld_if.mem_load_byte = 1'b1;
      ld_if.mem_load_unsigned = 1'b1;
      @(posedge clk); #1;
      ld_if.bus_ack = 1'b0;
      check("b2b_done1", 32'(ld_if.mem_stop_end), 32'd1);
      check("b2b_data1", ld_if.mem_load_data, 32'hA5A5_0001);
      @(posedge clk); #1;
      check("b2b_idle_busy", 32'(ld_if.mem_load_busy), 32'd0);
      check("b2b_idle_req", 32'(ld_if.bus_req), 32'd0);
      @(posedge clk); #1;
      ld_if.mem_load_valid = 1'b0;
      check("b2b_req2", 32'(ld_if.bus_req), 32'd1);
      check("b2b_addr2", ld_if.bus_addr, 32'h0000_0500);
      check("b2b_be2", 32'(ld_if.bus_be), 32'h4);
      ld_if.bus_ack = 1'b1;
      ld_if.bus_rdata = 32'h00C3_0000;
      @(posedge clk); #1;
      ld_if.bus_ack = 1'b0;
      check("b2b_done2", 32'(ld_if.mem_stop_end), 32'd1);
      check("b2b_data2", ld_if.mem_load_data, 32'h0000_00C3);
      @(posedge clk); #1;
      check("b2b_pulses", 32'(pulses - p0), 32'd2);

      // Reset asserted in REQ, late ack after release
      p0 = pulses;
      ld_if.mem_load_valid = 1'b1;
      ld_if.mem_addr = 32'h0000_0700;
      ld_if.mem_load_byte = 1'b0;
      @(posedge clk); #1;
      ld_if.mem_load_valid = 1'b0;
      check("rmid_req", 32'(ld_if.bus_req), 32'd1);
      rst = 1'b0;
      #1;
      check("rmid_req_drop", 32'(ld_if.bus_req), 32'd0);
      check("rmid_busy", 32'(ld_if.mem_load_busy), 32'd0);
      check("rmid_data", ld_if.mem_load_data, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      ld_if.bus_ack = 1'b1;
      ld_if.bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      ld_if.bus_ack = 1'b0;
      @(posedge clk); #1;
      check("rmid_no_pulse", 32'(pulses - p0), 32'd0);
      check("rmid_idle", 32'(ld_if.mem_load_busy), 32'd0);
      check("rmid_data_after", ld_if.mem_load_data, 32'h0);

      // Long wait: aborts when the timeout feature is built in, then a normal load clears err
      do_load(32'h0000_0800, 1'b0, 1'b0, 32'h5555_AAAA, 10);
      do_load(32'h0000_0801, 1'b1, 1'b0, 32'h0000_7F00, 0);
      check("err_cleared", 32'(ld_if.mem_load_err), 32'd0);

      // Randomized loads
      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         do_load(ra, 1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
MEM-stage load sequencer that produces the `mem_stop_end` release for the pipeline stall controller.
- On a load (LW/LB/LBU) from the MEM stage, it runs a request/acknowledge read on the data bus.
- It extracts and extends the addressed byte or word.
- It pulses `mem_stop_end` for one cycle when the loaded data is ready, which releases the IF/ID stall raised by ID.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for `bus_ack` before abort (used only with MEM_LOAD_TIMEOUT_EN); 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_load_valid  in  1  MEM stage presents a load this cycle.
- mem_load_byte  in  1  1 = byte load (LB/LBU), 0 = word load (LW).
- mem_load_unsigned  in  1  1 = zero-extend byte (LBU), 0 = sign-extend (LB); ignored for LW.
- mem_addr  in  32  load effective address.
- bus_req  out  1  read request to data bus.
- bus_addr  out  32  word-aligned read address.
- bus_be  out  4  byte enables.
- bus_ack  in  1  bus read complete; `bus_rdata` valid this cycle.
- bus_rdata  in  32  bus read data, little-endian lanes.
- mem_stop_end  out  1  one-cycle pulse: load finished, stall may end.
- mem_load_data  out  32  extended load result.
- mem_load_busy  out  1  high in REQ and DONE.
- mem_load_err  out  1  timeout abort flag (MEM_LOAD_TIMEOUT_EN only).

Behaviour:
- Reset (`rst` = 0, async): state = IDLE, `bus_req` = 0, `bus_addr` = 0, `bus_be` = 0, `mem_stop_end` = 0, `mem_load_data` = 0, `mem_load_busy` = 0, `mem_load_err` = 0, captured fields cleared.
- States: IDLE, REQ, DONE.
- IDLE:
  - When `mem_load_valid` = 1: capture `mem_addr`, `mem_load_byte`, `mem_load_unsigned`; go to REQ.
  - `bus_ack` is ignored.
- REQ:
  - `bus_req` = 1. `bus_addr` = {addr[31:2], 2'b00}.
  - `bus_be` = 4'b0001 << addr[1:0] for a byte load, 4'b1111 for a word load.
  - Address and enables are stable for the whole REQ period.
  - On `bus_ack` = 1: register the result into `mem_load_data`, go to DONE.
  - `mem_load_valid` is ignored while busy.
- DONE:
  - `mem_stop_end` = 1 for exactly this cycle; `bus_req` = 0; next state IDLE.
  - `mem_load_valid` is ignored in DONE; a new load is accepted from the following IDLE cycle.
- Result:
  - Word load: `bus_rdata` as is. Misaligned LW: low address bits ignored, no exception.
  - Byte load: b = `bus_rdata`[8*addr[1:0] +: 8]; sign-extend b[7] unless `mem_load_unsigned` = 1, then zero-extend.
- `mem_load_data` holds its value until the next captured result.
- Latency: valid at cycle 0 → `bus_req` at cycle 1 → earliest `bus_ack` at cycle 1 → `mem_stop_end` at cycle 2. Each extra wait cycle adds one cycle.
- `mem_load_busy` = 1 in REQ and DONE.
- Reset mid-operation: immediate return to IDLE with `bus_req` dropped. A late `bus_ack` after reset is ignored; no `mem_stop_end` is generated for the aborted load.

Optional Feature:
MEM_LOAD_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without `bus_ack`.
  - When it reaches TIMEOUT with no ack: go to DONE, `mem_load_data` = 0, `mem_load_err` = 1. `mem_stop_end` still pulses, so the pipeline never deadlocks.
  - `mem_load_err` stays set until the next accepted load, or reset.
  - An ack arriving on the same cycle as timeout wins: normal completion, no error.
- Not defined: counter absent, `mem_load_err` tied to 0, REQ waits indefinitely for `bus_ack`.

Test Plan:
- LW `mem_addr` = 0x0000_0100; ack 3 cycles after `bus_req`; `bus_rdata` = 0xDEADBEEF → `bus_addr` = 0x100, `bus_be` = 4'hF, `mem_stop_end` single pulse at cycle 5, `mem_load_data` = 0xDEADBEEF.
- LB `mem_addr` = 0x103; `bus_rdata` = 0x80112233; zero-wait ack → `bus_be` = 4'b1000, `bus_addr` = 0x100, `mem_stop_end` at cycle 2, data = 0xFFFFFF80.
- LBU `mem_addr` = 0x101; `bus_rdata` = 0x0000F100 → `bus_be` = 4'b0010, data = 0x000000F1. Then LB same data → 0xFFFFFFF1.
- Back-to-back: `mem_load_valid` held high across DONE → second load starts only in the IDLE cycle after the pulse; two distinct `mem_stop_end` pulses.
- `rst` = 0 asserted in REQ, ack arrives one cycle after release → `bus_req` = 0 immediately, no `mem_stop_end`, state IDLE, data = 0.
- MEM_LOAD_TIMEOUT_EN, TIMEOUT = 4, no ack → after 4 REQ cycles: `mem_stop_end` pulse, `mem_load_err` = 1, data = 0. Next load completes normally and clears `mem_load_err`.
